// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute unit: width, control codes and FSM states.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (ctrl, a, b, shamt) -> (result, illegal).
// ALU_EXEC_FAST_SHIFT_EN selects a full barrel shifter for SLL.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = alu_pkg::WIDTH
) (
  input  logic [3:0]   ctrl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [4:0]   shamt,
  output logic [W-1:0] result,
  output logic         illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_LUI: result = {b[15:0], {(W-16){1'b0}}};
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_EXEC_FAST_SHIFT_EN
      ALU_SLL: result = b << shamt;
`else
      // Nonzero shifts go through the serial path, so only shamt=0 lands here.
      ALU_SLL: result = (shamt == 5'd0) ? b : '0;
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Handshaked multi-cycle ALU execute unit with bit-serial SLL.
// Define ALU_EXEC_FAST_SHIFT_EN to make SLL single-cycle via a barrel shifter.
//
// state    | meaning
// ST_IDLE  | in_ready=1, waiting for a request
// ST_SHIFT | serial SLL in progress, one bit per cycle
// ST_DONE  | out_valid=1, result held until out_ready
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] core_result;
  logic             core_illegal;
  logic             start_shift;
  logic [WIDTH-1:0] acc_shl;

  alu_core #(.W(WIDTH)) u_core (
    .ctrl    (alu_ctrl),
    .a       (op_a),
    .b       (op_b),
    .shamt   (shamt),
    .result  (core_result),
    .illegal (core_illegal)
  );

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign start_shift = 1'b0;
`else
  assign start_shift = (alu_ctrl == ALU_SLL) && (shamt != 5'd0);
`endif

  assign acc_shl = {acc_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (start_shift) begin
            acc_d   = op_b;
            cnt_d   = shamt;
            state_d = ST_SHIFT;
          end else begin
            result_d  = core_result;
            zero_d    = (core_result == '0);
            illegal_d = core_illegal;
            state_d   = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = acc_shl;
        cnt_d = cnt_q - 5'd1;
        // The edge that takes cnt to zero also publishes the final shifted value.
        if (cnt_q == 5'd1) begin
          result_d  = acc_shl;
          zero_d    = (acc_shl == '0);
          illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus randomized ops against an arithmetic model.
module tb_alu_exec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks;
  int failures;

  alu_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, computed from the operation definitions with plain arithmetic.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic ill,
                                output int lat);
    longint unsigned ua, ub;
    ua  = longint'(a);
    ub  = longint'(b);
    ill = 1'b0;
    lat = 1;
    case (c)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = 32'((ua + ub) % 64'h1_0000_0000);
      4'd3: r = a ^ b;
      4'd5: r = 32'(((ub % 65536) * 65536) % 64'h1_0000_0000);
      4'd6: r = 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      4'd7: r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'd8: begin
        r = 32'((ub * (64'd1 << sh)) % 64'h1_0000_0000);
`ifndef ALU_EXEC_FAST_SHIFT_EN
        lat = int'(sh) + 1;
`endif
      end
      default: begin
        r   = 32'd0;
        ill = 1'b1;
      end
    endcase
  endfunction

  // Issue one op, measure latency, check outputs, hold for 'hold' cycles, then take.
  task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input int hold);
    logic [31:0] exp_r;
    logic        exp_ill;
    int          exp_lat;
    int          lat;
    model(c, a, b, sh, exp_r, exp_ill, exp_lat);
    chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    shamt    = sh;
    @(posedge clk); #1;
    in_valid = $urandom_range(0, 1);
    alu_ctrl = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    shamt    = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) chk({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".result"}, result, exp_r);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_r == 32'd0});
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      op_a = $urandom;
      chk({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".hold_result"}, result, exp_r);
      chk({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".taken_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".taken_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    shamt     = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.zero", {31'd0, zero}, 32'd0);
    chk("rst.illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
    do_op("slt_neg", 4'b0111, 32'hFFFF_FFFE, 32'd3, 5'd0, 0);
    do_op("sub_neg", 4'b0110, 32'd5, 32'd7, 5'd0, 0);
    do_op("sll_31", 4'b1000, 32'h0000_0001, 32'h0000_0001, 5'd31, 0);
    do_op("lui_hold", 4'b0101, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 5);
    do_op("illegal_f", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 1);
    do_op("sll_0", 4'b1000, 32'h0, 32'hA5A5_0001, 5'd0, 0);
    do_op("sll_zero_res", 4'b1000, 32'h0, 32'h0000_0100, 5'd24, 0);

    // Reset in the middle of a 20-bit serial shift, 10 bits in.
    in_valid = 1'b1;
    alu_ctrl = 4'b1000;
    op_b     = 32'h0000_0003;
    shamt    = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`ifndef ALU_EXEC_FAST_SHIFT_EN
    chk("mid.out_valid", {31'd0, out_valid}, 32'd0);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst.result", result, 32'd0);
    chk("mid_rst.zero", {31'd0, zero}, 32'd0);
    chk("mid_rst.illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 5'd0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0]  rc;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [4:0]  rs;
      rc = 4'($urandom);
      if (n % 3 == 0) rc = 4'b1000;
      ra = $urandom;
      rb = $urandom;
      if (n % 5 == 0) rb = ra;
      rs = 5'($urandom);
      do_op($sformatf("rand%0d", n), rc, ra, rb, rs, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Handshaked, multi-cycle ALU execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two 32-bit operands and a shift amount. It is the receiving end of the decoder's `alu_ctrl_out` interface. Most operations complete in one cycle; SLL runs bit-serially at one bit per cycle. Results are held under a valid/ready output handshake. It sits between the register-read/operand-mux stage and write-back in the multi-cycle datapath.

## Interface
- `WIDTH`, default 32: operand and result width. Supported value: 32 only. LUI and the 5-bit shamt depend on it.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit can accept a request; high only in IDLE.
- `alu_ctrl` input 4: operation code.
- `op_a` input WIDTH: operand A.
- `op_b` input WIDTH: operand B.
- `shamt` input 5: shift amount; used only for SLL.
- `out_valid` output 1: result valid; high only in DONE.
- `out_ready` input 1: consumer takes the result.
- `result` output WIDTH: registered result.
- `zero` output 1: registered flag, `result == 0`.
- `illegal` output 1: registered flag, unknown `alu_ctrl` code.

## Operation
- Codes:
  - 0000 AND: a&b.
  - 0001 OR: a|b.
  - 0010 ADD: a+b, modulo 2^32, no overflow flag.
  - 0011 XOR: a^b.
  - 0101 LUI: {b[15:0],16'h0}.
  - 0110 SUB: a−b, modulo 2^32.
  - 0111 SLT: 1 if $signed(a) < $signed(b), else 0.
  - 1000 SLL: b << shamt.
- Any other code: result=0, zero=1, illegal=1. Completes with 1-cycle latency.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, the request is accepted.
  - If the code is not SLL, or it is SLL with shamt=0: the result is computed and registered on the accept edge; next state is DONE.
  - If the code is SLL with shamt≠0: acc←b and cnt←shamt; next state is SHIFT.
- SHIFT: each edge performs acc←acc<<1 and cnt←cnt−1. When cnt becomes 0, result←shifted acc, flags are updated, and the next state is DONE. in_valid is ignored in this state.
- DONE: out_valid=1. result, zero and illegal are held stable until out_ready=1. On out_valid&&out_ready, the next state is IDLE.
  - No accept occurs in the same cycle as the result is taken; in_ready stays 0 in DONE.
- Inputs are sampled only on the accept edge. Later changes to op_a, op_b, shamt or alu_ctrl do not affect an operation already in progress.
- Reset mid-operation: returns to IDLE immediately, and any partial shift is discarded.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, illegal=0, acc=0, cnt=0.
- Latency from the accept edge to out_valid high:
  - 1 cycle for all non-SLL codes, illegal codes, and SLL with shamt=0.
  - shamt+1 cycles for SLL with shamt≠0. Maximum is 32 (shamt=31).
- Minimum spacing between accepts is 2 cycles (accept, then take with out_ready=1).
- out_valid never drops without a handshake. result never changes while out_valid=1.

## Configuration
- `ALU_EXEC_FAST_SHIFT_EN`:
  - Defined: SLL uses a combinational barrel shifter, so every code has 1-cycle latency and the SHIFT state is never entered.
  - Undefined: SLL uses the bit-serial SHIFT path described above.
  - Results are identical in both builds; only latency differs.

## Structure
- Shared package `alu_pkg`:
  - Localparams for the 8 ctrl codes (ALU_AND … ALU_SLL).
  - The FSM state enum/encoding.
  - The WIDTH constant.
- Sub-module `alu_core`: purely combinational; maps (ctrl, a, b, shamt) to (result, illegal). It is used on the accept edge. The FSM, shift accumulator and handshake stay in `alu_exec`.

## Test plan
- ADD a=32'hFFFF_FFFF, b=1, out_ready=1 -> out_valid 1 cycle after accept, result=0, zero=1, illegal=0.
- SLT a=32'hFFFF_FFFE (−2), b=3 -> result=1. Then SUB a=5, b=7 -> result=32'hFFFF_FFFE, zero=0.
- SLL b=32'h0000_0001, shamt=31 -> out_valid exactly 32 cycles after accept (1 cycle with FAST_SHIFT_EN), result=32'h8000_0000. in_ready=0 throughout.
- LUI b=32'h0000_1234 -> result=32'h1234_0000. Hold out_ready=0 for 5 cycles -> result is stable, in_ready=0, and out_valid=1 until the take.
- ctrl=4'b1111 -> result=0, zero=1, illegal=1, latency 1.
- Assert rst_n=0 while in SHIFT with shamt=20 at cnt=10 -> all outputs show reset values immediately. After release, a new ADD 2+3 returns result=5.
